regfile_sb: RTL and testbench

Parametrised successor to the lab 3-port register file (clk/we3/wa3/wd3/ra1/ra2).
- Generalised in data width, register count and read-port count.
- Adds an async active-low clear and a pending-write scoreboard, so the pipelined datapath can detect RAW hazards.
- Sits between the decode stage (reads, issue marking) and the writeback stage (we3/wa3/wd3).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_score.sv | 78 +++++++
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
// Shared constants, count type and address-validity helper for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 32;

    typedef logic [$clog2(NREGS_DEF + 1)-1:0] pend_cnt_t;

    // Register 0 is hard-wired when zeroReg is set, so it is never a real target.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs,
                                        input bit zeroReg);
        return (addr < nregs) && !(zeroReg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_score.sv
`timescale 1ns/1ps
// Pending-write scoreboard: one bit per register, an exact popcount and per-port busy lookup.
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy,
    output logic [CW-1:0]     pendCnt
);

    logic [NREGS-1:0] pendingQ, pendingD;
    logic [CW-1:0]    cntQ, cntD;
    logic             wrEn, issEn, wrHit, issHit;

    assign wrEn  = we3 && addr_valid(32'(wa3), NREGS, ZERO_REG);
    assign issEn = iss_valid && addr_valid(32'(iss_addr), NREGS, ZERO_REG);

    always_comb begin
        pendingD = pendingQ;
        wrHit    = 1'b0;
        issHit   = 1'b0;
        // Issue is applied after the clear so a same-cycle issue wins.
        for (int unsigned j = 0; j < NREGS; j++) begin
            if (wrEn && (wa3 == AW'(j))) begin
                pendingD[j] = 1'b0;
                wrHit       = pendingQ[j];
            end
            if (issEn && (iss_addr == AW'(j))) begin
                pendingD[j] = 1'b1;
                issHit      = pendingQ[j];
            end
        end
        cntD = cntQ;
        if (issEn && !issHit) begin
            cntD = cntD + CW'(1);
        end
        if (wrEn && wrHit && !(issEn && (iss_addr == wa3))) begin
            cntD = cntD - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pendingQ <= '0;
            cntQ     <= '0;
        end else begin
            pendingQ <= pendingD;
            cntQ     <= cntD;
        end
    end

    // Out-of-range addresses match no entry and register 0 is never set, so both read as idle.
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            for (int unsigned j = 0; j < NREGS; j++) begin
                if (ra[i*AW +: AW] == AW'(j)) begin
                    busy[i] = pendingQ[j];
                end
            end
        end
    end

    assign pendCnt = cntQ;

endmodule

// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
// Parametrised register file with pending-write scoreboard for RAW hazard detection.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = $clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we3,
    input  logic [AW-1:0]         wa3,
    input  logic [DATA_W-1:0]     wd3,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr,
    output logic [CW-1:0]         pend_cnt
);

    logic [DATA_W-1:0] regsQ [NREGS];
    logic              wrValid;
    logic [NRD-1:0]    scoreBusy;

    assign wrValid = we3 && addr_valid(32'(wa3), NREGS, ZERO_REG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < NREGS; j++) begin
                regsQ[j] <= '0;
            end
        end else if (wrValid) begin
            for (int unsigned j = 0; j < NREGS; j++) begin
                if (wa3 == AW'(j)) begin
                    regsQ[j] <= wd3;
                end
            end
        end
    end

    regfile_sb_score #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_score (
        .clk       (clk),
        .reset_n   (reset_n),
        .we3       (we3),
        .wa3       (wa3),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .ra        (ra),
        .busy      (scoreBusy),
        .pendCnt   (pend_cnt)
    );

    always_comb begin
        rd      = '0;
        rd_busy = scoreBusy;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (addr_valid(32'(ra[i*AW +: AW]), NREGS, ZERO_REG)) begin
                for (int unsigned j = 0; j < NREGS; j++) begin
                    if (ra[i*AW +: AW] == AW'(j)) begin
                        rd[i*DATA_W +: DATA_W] = regsQ[j];
                    end
                end
            end
`ifdef REGFILE_BYPASS_EN
            // The in-flight writeback value is the freshest copy and resolves the hazard.
            if (wrValid && (wa3 == ra[i*AW +: AW])) begin
                rd[i*DATA_W +: DATA_W] = wd3;
                rd_busy[i]             = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
// Directed self-checking bench for regfile_sb: default instance plus a 20-register instance.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, we3, iss_valid;
    logic [4:0]  wa3, iss_addr, ra0, ra1;
    logic [31:0] wd3;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    pend_cnt_t   pend_cnt;

    logic        we3S, issS;
    logic [4:0]  wa3S, issAddrS, raS0, raS1;
    logic [31:0] wd3S;
    logic [63:0] rdS;
    logic [1:0]  busyS;
    logic [4:0]  cntS;

    int testsRun  = 0;
    int failCount = 0;

    regfile_sb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra        ({ra1, ra0}),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .pend_cnt  (pend_cnt)
    );

    regfile_sb #(.NREGS(20)) dut20 (
        .clk       (clk),
        .reset_n   (reset_n),
        .we3       (we3S),
        .wa3       (wa3S),
        .wd3       (wd3S),
        .ra        ({raS1, raS0}),
        .rd        (rdS),
        .rd_busy   (busyS),
        .iss_valid (issS),
        .iss_addr  (issAddrS),
        .pend_cnt  (cntS)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; iss_valid = 1'b0; iss_addr = '0;
        ra0 = 5'd5; ra1 = 5'd31;
        we3S = 1'b0; wa3S = '0; wd3S = '0; issS = 1'b0; issAddrS = '0;
        raS0 = 5'd25; raS1 = 5'd19;

        // Reset state
        #2;
        check("reset_rd", rd, 64'd0);
        check("reset_busy", 64'(rd_busy), 64'd0);
        check("reset_cnt", 64'(pend_cnt), 64'd0);
        #14 reset_n = 1'b1;
        tick();
        check("post_reset_rd", rd, 64'd0);

        // Basic write/read, and register 0 stays zero and never pends
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'd12;
        tick();
        we3 = 1'b0; ra0 = 5'd3;
        #1 check("rd_reg3", 64'(rd[31:0]), 64'd12);
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_addr = 5'd0;
        tick();
        we3 = 1'b0; iss_valid = 1'b0; ra0 = 5'd0;
        #1 check("rd_reg0", 64'(rd[31:0]), 64'd0);
        check("busy_reg0", 64'(rd_busy[0]), 64'd0);
        check("cnt_issue0", 64'(pend_cnt), 64'd0);

        // Issue 4 then 7, redundant issue to 4
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0; ra0 = 5'd4; ra1 = 5'd7;
        #1 check("cnt_two", 64'(pend_cnt), 64'd2);
        check("busy_4_7", 64'(rd_busy), 64'b11);
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        iss_valid = 1'b0;
        check("cnt_redundant", 64'(pend_cnt), 64'd2);

        // Writeback to 4 clears its pending bit
        we3 = 1'b1; wa3 = 5'd4; wd3 = 32'd44;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pre_edge_rd4", 64'(rd[31:0]), 64'd44);
        check("pre_edge_busy4", 64'(rd_busy), 64'b10);
`else
        check("pre_edge_rd4", 64'(rd[31:0]), 64'd0);
        check("pre_edge_busy4", 64'(rd_busy), 64'b11);
`endif
        tick();
        we3 = 1'b0;
        #1 check("cnt_after_wb4", 64'(pend_cnt), 64'd1);
        check("busy_after_wb4", 64'(rd_busy), 64'b10);
        check("rd_reg4", 64'(rd[31:0]), 64'd44);

        // Issue + write same address: pending 9 stays set, count unchanged
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        check("cnt_issue9", 64'(pend_cnt), 64'd2);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'd77;
        tick();
        we3 = 1'b0; iss_valid = 1'b0; ra0 = 5'd9;
        #1 check("rd_reg9", 64'(rd[31:0]), 64'd77);
        check("busy_reg9", 64'(rd_busy), 64'b11);
        check("cnt_iss_wr9", 64'(pend_cnt), 64'd2);
        // Same on a clear register 10: count rises by one
        iss_valid = 1'b1; iss_addr = 5'd10; we3 = 1'b1; wa3 = 5'd10; wd3 = 32'd100;
        tick();
        iss_valid = 1'b0; we3 = 1'b0;
        check("cnt_iss_wr10", 64'(pend_cnt), 64'd3);

        // Bypass visibility on port 1
        we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h0000_1111;
        tick();
        wd3 = 32'hA5A5_0000; ra1 = 5'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pre_edge_rd1", 64'(rd[63:32]), 64'hA5A5_0000);
`else
        check("pre_edge_rd1", 64'(rd[63:32]), 64'h0000_1111);
`endif
        check("pre_edge_busy1", 64'(rd_busy[1]), 64'd0);
        tick();
        we3 = 1'b0;
        check("rd1_after_edge", 64'(rd[63:32]), 64'hA5A5_0000);
        check("cnt_before_rst", 64'(pend_cnt), 64'd3);

        // Mid-run asynchronous reset
        ra0 = 5'd3;
        #1 reset_n = 1'b0;
        #1 check("midrst_rd", rd, 64'd0);
        check("midrst_cnt", 64'(pend_cnt), 64'd0);
        check("midrst_busy", 64'(rd_busy), 64'd0);
        #2 reset_n = 1'b1;
        tick();
        check("post_midrst_rd3", 64'(rd[31:0]), 64'd0);

        // 20-register instance: out-of-range write/issue ignored, top register usable
        we3S = 1'b1; wa3S = 5'd25; wd3S = 32'hDEAD; issS = 1'b1; issAddrS = 5'd25;
        tick();
        wa3S = 5'd19; wd3S = 32'h55; issS = 1'b0;
        tick();
        we3S = 1'b0;
        check("n20_rd25", 64'(rdS[31:0]), 64'd0);
        check("n20_rd19", 64'(rdS[63:32]), 64'h55);
        check("n20_busy", 64'(busyS), 64'd0);
        check("n20_cnt0", 64'(cntS), 64'd0);
        issS = 1'b1; issAddrS = 5'd19;
        tick();
        issS = 1'b0;
        check("n20_cnt1", 64'(cntS), 64'd1);
        check("n20_busy19", 64'(busyS), 64'b10);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
